// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: oversampled I2S slave receiver delivering L/R pairs on valid/ready; define I2S_RX_LJ_EN for left-justified framing
module i2s_slave_rx #(
  parameter int d_width = 24,
  parameter int sclk_ws_ratio = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               ws,
  input  logic               sd,
  input  logic               rx_ready,
  output logic               rx_valid,
  output logic [d_width-1:0] l_data_rx,
  output logic [d_width-1:0] r_data_rx,
  output logic               overrun
);
  localparam int bw = $clog2(sclk_ws_ratio / 2) + 1;
  typedef enum logic {sync_st, run_st} state_t;
  state_t state;
  logic [2:0] sclk_s;
  logic [1:0] ws_s, sd_s;
  logic rise, ws_d, sd_d, ws_prev, l_got, full, pair;
  logic [d_width-1:0] shreg, l_hold, sh_in, word;
  logic [bw-1:0] bitcnt, cnt_in;
  always_comb begin
    full = 32'(bitcnt) >= d_width;
    sh_in = full ? shreg : {shreg[d_width-2:0], sd_d};
    cnt_in = full ? bitcnt : bitcnt + bw'(1);
`ifdef I2S_RX_LJ_EN
    word = shreg << (d_width - 32'(bitcnt));
`else
    word = sh_in << (d_width - 32'(cnt_in));
`endif
    pair = rise && state == run_st && ws_prev && !ws_d && l_got;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= sync_st;
      sclk_s <= '0;
      ws_s <= '0;
      sd_s <= '0;
      rise <= 1'b0;
      ws_d <= 1'b0;
      sd_d <= 1'b0;
      ws_prev <= 1'b0;
      l_got <= 1'b0;
      shreg <= '0;
      bitcnt <= '0;
      l_hold <= '0;
      rx_valid <= 1'b0;
      l_data_rx <= '0;
      r_data_rx <= '0;
      overrun <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      ws_s <= {ws_s[0], ws};
      sd_s <= {sd_s[0], sd};
      rise <= sclk_s[1] & ~sclk_s[2];
      ws_d <= ws_s[1];
      sd_d <= sd_s[1];
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (rise) begin
        ws_prev <= ws_d;
        if (state == sync_st) begin
          if (ws_prev && !ws_d) begin
            state <= run_st;
`ifdef I2S_RX_LJ_EN
            shreg <= d_width'(sd_d);
            bitcnt <= bw'(1);
`else
            shreg <= '0;
            bitcnt <= '0;
`endif
          end
        end else if (ws_d == ws_prev) begin
          shreg <= sh_in;
          bitcnt <= cnt_in;
        end else begin
          if (!ws_prev) begin
            l_hold <= word;
            l_got <= 1'b1;
          end
`ifdef I2S_RX_LJ_EN
          shreg <= d_width'(sd_d);
          bitcnt <= bw'(1);
`else
          shreg <= '0;
          bitcnt <= '0;
`endif
        end
      end
      if (pair) begin
        if (!rx_valid || rx_ready) begin
          l_data_rx <= l_hold;
          r_data_rx <= word;
          rx_valid <= 1'b1;
        end else overrun <= 1'b1;
      end
    end
  end
endmodule
